// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce
// ----------------------------------------------------------------------------
// Input-conditioning stage in front of pong_top. It debounces the four raw
// paddle pushbuttons (two per player) and the AI-mode slide switch, and
// produces clean levels plus one-cycle press ticks.
//
// Five independent channels (btn1[0], btn1[1], btn2[0], btn2[1], ai). Each
// channel has its own four-state FSM (ZERO, WAIT1, ONE, WAIT0) and its own
// CNT_W-bit down counter. A level change is accepted only after the new
// value has been sampled DB_TICKS+1 times in a row. Any opposite sample
// during a WAIT state aborts back to the previous stable state. The counter
// is reloaded on the next attempt; it never resumes a partial count.
//
// Configuration macro:
//   BTN_SYNC_EN  defined   : every raw input passes through a two-flop
//                            synchroniser (reset to 0) before its FSM. All
//                            latencies grow by 2 cycles.
//                undefined : raw inputs feed the FSMs directly. Use this only
//                            for inputs that are already synchronous, or in
//                            simulation.
//
// Parameters:
//   DB_TICKS  stable cycles required before a level change
//   CNT_W     counter width; 2**CNT_W must be greater than DB_TICKS
//
// Ports:
//   clk        in   1  system clock, shared with pong_top
//   reset      in   1  synchronous, active-high reset
//   btn1_raw   in   2  player-1 raw buttons {down,up}, active-high
//   btn2_raw   in   2  player-2 raw buttons {down,up}, active-high
//   ai_raw     in   1  raw AI-mode slide switch
//   btn1       out  2  debounced player-1 levels
//   btn2       out  2  debounced player-2 levels
//   btn1_tick  out  2  1-cycle pulse on each debounced 0->1 of a btn1 bit
//   btn2_tick  out  2  1-cycle pulse on each debounced 0->1 of a btn2 bit
//   any_tick   out  1  OR of the four press ticks, in the same cycle
//   ai_switch  out  1  debounced ai_raw level
//
// Each channel's FSM state is held in g_ch[i].state_q.
// Channel index: 0,1 = btn1[0],btn1[1]; 2,3 = btn2[0],btn2[1]; 4 = ai.
// ============================================================================
module btn_debounce #(
    parameter int DB_TICKS = 1_000_000,
    parameter int CNT_W    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn1_raw,
    input  logic [1:0] btn2_raw,
    input  logic       ai_raw,
    output logic [1:0] btn1,
    output logic [1:0] btn2,
    output logic [1:0] btn1_tick,
    output logic [1:0] btn2_tick,
    output logic       any_tick,
    output logic       ai_switch
);

    localparam int N_CH  = 5;
    localparam int N_BTN = 4;

    // Value loaded into the counter when a WAIT state is entered. The WAIT
    // state then spends DB_TICKS further cycles (cnt = DB_TICKS-1 down to 0)
    // before it commits the change.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic [N_CH-1:0]  raw_all;
    logic [N_CH-1:0]  in_all;
    logic [N_CH-1:0]  level_all;
    logic [N_BTN-1:0] tick_all;

    assign raw_all = {ai_raw, btn2_raw, btn1_raw};

    // ------------------------------------------------------------------
    // Optional two-flop synchroniser in front of the FSMs
    // ------------------------------------------------------------------
`ifdef BTN_SYNC_EN
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_all;
            sync2_q <= sync1_q;
        end
    end

    assign in_all = sync2_q;
`else
    assign in_all = raw_all;
`endif

    // ------------------------------------------------------------------
    // Per-channel debounce FSM
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             in_s;

        assign in_s = in_all[g];

        // The level is registered together with the state. It goes high on
        // WAIT1->ONE and low on WAIT0->ZERO, so it is 1 exactly in ONE and
        // WAIT0.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ZERO;
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ZERO: begin
                        if (in_s) begin
                            state_q <= WAIT1;
                            cnt_q   <= RELOAD;
                        end
                    end
                    WAIT1: begin
                        if (!in_s) begin
                            // Bounce: give up and restart from scratch later.
                            state_q <= ZERO;
                        end else if (cnt_q == '0) begin
                            state_q <= ONE;
                            level_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ONE: begin
                        if (!in_s) begin
                            state_q <= WAIT0;
                            cnt_q   <= RELOAD;
                        end
                    end
                    WAIT0: begin
                        if (in_s) begin
                            state_q <= ONE;
                        end else if (cnt_q == '0) begin
                            state_q <= ZERO;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ZERO;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign level_all[g] = level_q;

        // Press tick for button channels only. It is raised on the same edge
        // that takes WAIT1->ONE, so it coincides with the first cycle of
        // level = 1. A held button stays in ONE and cannot tick again.
        if (g < N_BTN) begin : g_tick
            logic tick_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    tick_q <= 1'b0;
                end else begin
                    tick_q <= (state_q == WAIT1) && in_s && (cnt_q == '0);
                end
            end

            assign tick_all[g] = tick_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign btn1      = level_all[1:0];
    assign btn2      = level_all[3:2];
    assign ai_switch = level_all[4];
    assign btn1_tick = tick_all[1:0];
    assign btn2_tick = tick_all[3:2];
    assign any_tick  = |tick_all;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DB_TICKS=8, CNT_W=4.
// Cycle c means the interval after the c-th rising edge that follows reset
// release. An input set during cycle c is first sampled at edge c+1.
// Expected times below are hand-derived from the 9-sample acceptance rule.
// With BTN_SYNC_EN every expected time moves by SX = 2.
module tb_btn_debounce;

    localparam int DB = 8;
`ifdef BTN_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn1_raw;
    logic [1:0] btn2_raw;
    logic       ai_raw;
    logic [1:0] btn1;
    logic [1:0] btn2;
    logic [1:0] btn1_tick;
    logic [1:0] btn2_tick;
    logic       any_tick;
    logic       ai_switch;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    btn_debounce #(
        .DB_TICKS(DB),
        .CNT_W   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn1_raw (btn1_raw),
        .btn2_raw (btn2_raw),
        .ai_raw   (ai_raw),
        .btn1     (btn1),
        .btn2     (btn2),
        .btn1_tick(btn1_tick),
        .btn2_tick(btn2_tick),
        .any_tick (any_tick),
        .ai_switch(ai_switch)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Advance one clock edge and settle, so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    function automatic logic [31:0] all_out();
        return {22'd0, btn1, btn2, btn1_tick, btn2_tick, any_tick, ai_switch};
    endfunction

    // Hold reset for n edges with all raw inputs low. Check that every
    // output is 0 during reset, then release and restart the cycle count.
    task automatic do_reset(input int n);
        reset    = 1'b1;
        btn1_raw = 2'b00;
        btn2_raw = 2'b00;
        ai_raw   = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check_eq("rst_outs", all_out(), 32'd0);
        end
        reset = 1'b0;
        cyc   = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        btn1_raw = 2'b00;
        btn2_raw = 2'b00;
        ai_raw   = 1'b0;

        // Test 1: reset for 3 cycles with idle inputs. Outputs stay 0 during
        // and after reset.
        do_reset(3);
        for (int c = 1; c <= 5; c++) begin
            step();
            check_eq("idle_outs", all_out(), 32'd0);
        end

        // Test 2: btn1_raw[0] rises at cycle 10 and is held. Level and tick
        // appear at cycle 19; exactly one tick.
        step_to(10);
        btn1_raw[0] = 1'b1;
        for (int c = 11; c <= 25 + SX; c++) begin
            step();
            check_eq("t2_lvl",  btn1[0],      (cyc >= 19 + SX));
            check_eq("t2_tick", btn1_tick[0], (cyc == 19 + SX));
            check_eq("t2_any",  any_tick,     (cyc == 19 + SX));
        end

        // Test 3: btn2_raw[1] bounces 1,0,1,0 over cycles 16..19 (relative to
        // a new count), then is stable 1 from cycle 20. Single tick at 29.
        cyc = 0;
        step_to(16);
        for (int c = 16; c <= 31 + SX; c++) begin
            if (c < 20) btn2_raw[1] = ((c - 16) % 2 == 0);
            else        btn2_raw[1] = 1'b1;
            step();
            check_eq("t3_lvl",  btn2[1],      (cyc >= 29 + SX));
            check_eq("t3_tick", btn2_tick[1], (cyc == 29 + SX));
            check_eq("t3_b1tk", btn1_tick,    32'd0);
        end

        // Test 4: btn1[0] is stable high. A 5-cycle dropout is rejected. A
        // sustained drop clears the level 9 cycles later, with no tick.
        cyc = 0;
        step_to(35);
        btn1_raw[0] = 1'b0;
        for (int c = 36; c <= 50; c++) begin
            if (c == 40) btn1_raw[0] = 1'b1;
            step();
            check_eq("t4_glitch_lvl",  btn1[0],      32'd1);
            check_eq("t4_glitch_tick", btn1_tick[0], 32'd0);
        end
        btn1_raw[0] = 1'b0;
        for (int c = 51; c <= 64; c++) begin
            step();
            check_eq("t4_fall_lvl",  btn1[0],      (cyc < 59 + SX));
            check_eq("t4_fall_tick", btn1_tick[0], 32'd0);
        end

        // Test 5a: three buttons rise together at cycle 5. Three ticks at
        // cycle 14; any_tick lasts one cycle.
        do_reset(2);
        step_to(5);
        btn1_raw = 2'b11;
        btn2_raw = 2'b01;
        for (int c = 6; c <= 18 + SX; c++) begin
            step();
            check_eq("t5_b1tk", btn1_tick, (cyc == 14 + SX) ? 32'h3 : 32'h0);
            check_eq("t5_b2tk", btn2_tick, (cyc == 14 + SX) ? 32'h1 : 32'h0);
            check_eq("t5_any",  any_tick,  (cyc == 14 + SX));
            check_eq("t5_lvl",  {btn1, btn2}, (cyc >= 14 + SX) ? 32'hD : 32'h0);
        end

        // Test 5b: rerun with a reset pulse at cycle 10, in the middle of the
        // count. Outputs are 0 at cycle 11 and there is no tick at 14. The
        // held buttons then count as a fresh press at 11+9 = 20.
        do_reset(2);
        step_to(5);
        btn1_raw = 2'b11;
        btn2_raw = 2'b01;
        step_to(10);
        reset = 1'b1;
        step();
        check_eq("t5r_rst", all_out(), 32'd0);
        reset = 1'b0;
        for (int c = 12; c <= 23 + SX; c++) begin
            step();
            check_eq("t5r_any", any_tick,     (cyc == 20 + SX));
            check_eq("t5r_lvl", {btn1, btn2}, (cyc >= 20 + SX) ? 32'hD : 32'h0);
        end

        // Test 6: ai_raw rises at cycle 10. ai_switch rises at 19 (21 with
        // the synchroniser) and never produces a tick.
        do_reset(2);
        step_to(10);
        ai_raw = 1'b1;
        for (int c = 11; c <= 24; c++) begin
            step();
            check_eq("t6_ai",  ai_switch, (cyc >= 19 + SX));
            check_eq("t6_any", any_tick,  32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
